// File: rtl/cbb_reg_slice.sv
// cbb_reg_slice: two-entry valid/ready skid buffer that registers in_ready and keeps full throughput.
module cbb_reg_slice #(
    parameter int               WIDTH    = 8,
    parameter logic [WIDTH-1:0] INIT_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready,
    output logic [1:0]       occupancy
);
    logic             main_valid, skid_valid;
    logic [WIDTH-1:0] main_data, skid_data;
    logic             in_xfer;

    assign in_ready  = !skid_valid && !clr;
    assign in_xfer   = in_valid && in_ready;
    assign out_valid = main_valid;
    assign out_data  = main_data;
    assign occupancy = {1'b0, main_valid} + {1'b0, skid_valid};

    // skid_valid implies main_valid, so the branches below are EMPTY/BUSY/FULL in disguise
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
            main_data  <= INIT_VAL;
            skid_data  <= INIT_VAL;
        end else if (clr) begin
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
            main_data  <= INIT_VAL;
            skid_data  <= INIT_VAL;
        end else if (skid_valid) begin
            if (out_ready) begin
                main_data  <= skid_data;
                skid_valid <= 1'b0;
            end
        end else if (main_valid) begin
            if (in_xfer && out_ready) begin
                main_data <= in_data;
            end else if (in_xfer) begin
                skid_data  <= in_data;
                skid_valid <= 1'b1;
            end else if (out_ready) begin
                main_valid <= 1'b0;
            end
        end else if (in_xfer) begin
            main_data  <= in_data;
            main_valid <= 1'b1;
        end
    end
endmodule

// File: tb/tb_cbb_reg_slice.sv
// tb_cbb_reg_slice: directed and randomized checks of the skid buffer against a queue model.
module tb_cbb_reg_slice;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       clr = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       in_ready;
    logic       out_valid;
    logic [7:0] out_data;
    logic       out_ready = 1'b0;
    logic [1:0] occupancy;

    int   n_cmp = 0;
    int   n_err = 0;
    int   acc_cnt = 0;
    logic acc = 1'b0;
    logic hold_prev = 1'b0;
    logic [7:0] prev_data = 8'h00;
    logic [7:0] q[$];

    cbb_reg_slice #(.WIDTH(8), .INIT_VAL(8'h00)) dut (
        .clk(clk), .rst(rst), .clr(clr),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
        .occupancy(occupancy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: an ordered list of at most two held beats
    always @(posedge clk or negedge rst) begin
        if (!rst || clr) begin
            q.delete();
        end else begin
            bit pop, push;
            pop  = q.size() > 0 && out_ready;
            push = in_valid && q.size() < 2;
            if (pop) void'(q.pop_front());
            if (push) begin
                q.push_back(in_data);
                acc_cnt++;
            end
        end
    end

    always @(negedge clk) begin
        check("out_valid", {31'b0, out_valid}, {31'b0, q.size() > 0});
        check("in_ready", {31'b0, in_ready}, {31'b0, q.size() < 2 && !clr});
        check("occupancy", {30'b0, occupancy}, q.size());
        if (q.size() > 0) check("out_data", {24'b0, out_data}, {24'b0, q[0]});
        if (hold_prev && rst) begin
            check("hold_valid", {31'b0, out_valid}, 32'd1);
            check("hold_data", {24'b0, out_data}, {24'b0, prev_data});
        end
        hold_prev = out_valid && !out_ready && !clr && rst;
        prev_data = out_data;
    end

    task automatic cycle();
        @(negedge clk);
        acc = in_valid && in_ready;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int cyc;
        int start;
        in_valid = 1'b1;
        in_data  = 8'hAA;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("rst_out_valid", {31'b0, out_valid}, 32'd0);
        check("rst_in_ready", {31'b0, in_ready}, 32'd1);
        check("rst_occupancy", {30'b0, occupancy}, 32'd0);
        check("rst_out_data", {24'b0, out_data}, 32'h00);
        rst = 1'b1;
        cycle();
        check("post_rst_valid", {31'b0, out_valid}, 32'd1);
        check("post_rst_data", {24'b0, out_data}, 32'hAA);

        out_ready = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            in_data = 8'(i);
            check("stream_in_ready", {31'b0, in_ready}, 32'd1);
            cycle();
            check("stream_data", {24'b0, out_data}, i);
        end
        in_valid = 1'b0;
        cycle();
        check("stream_drained", {31'b0, out_valid}, 32'd0);

        out_ready = 1'b0;
        in_valid = 1'b1;
        in_data = 8'h11; cycle();
        in_data = 8'h22; cycle();
        in_data = 8'h33;
        check("bp_occ", {30'b0, occupancy}, 32'd2);
        check("bp_in_ready", {31'b0, in_ready}, 32'd0);
        cycle();
        check("bp_hold_data", {24'b0, out_data}, 32'h11);
        out_ready = 1'b1;
        cycle();
        check("bp_second", {24'b0, out_data}, 32'h22);
        cycle();
        check("bp_third", {24'b0, out_data}, 32'h33);
        check("bp_third_occ", {30'b0, occupancy}, 32'd1);
        in_valid = 1'b0;
        cycle();
        check("bp_drained", {31'b0, out_valid}, 32'd0);

        out_ready = 1'b0;
        in_valid = 1'b1;
        in_data = 8'h5A; cycle();
        in_data = 8'hA5; cycle();
        check("flush_full", {30'b0, occupancy}, 32'd2);
        clr = 1'b1;
        in_data = 8'h77;
        check("flush_in_ready", {31'b0, in_ready}, 32'd0);
        cycle();
        clr = 1'b0;
        in_valid = 1'b0;
        check("flush_occ", {30'b0, occupancy}, 32'd0);
        check("flush_valid", {31'b0, out_valid}, 32'd0);
        cycle();
        check("flush_no_77", {30'b0, occupancy}, 32'd0);

        in_valid = 1'b1;
        in_data = 8'hC1; cycle();
        in_data = 8'hC2; cycle();
        in_valid = 1'b0;
        check("arst_full", {30'b0, occupancy}, 32'd2);
        #3 rst = 1'b0;
        #1;
        check("arst_valid", {31'b0, out_valid}, 32'd0);
        check("arst_occ", {30'b0, occupancy}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        in_valid = 1'b1;
        in_data = 8'hD4;
        cycle();
        in_valid = 1'b0;
        check("arst_alone_occ", {30'b0, occupancy}, 32'd1);
        check("arst_alone_data", {24'b0, out_data}, 32'hD4);
        cycle();
        check("arst_alone_hold", {30'b0, occupancy}, 32'd1);

        cyc = 0;
        acc = 1'b0;
        start = acc_cnt;
        while (acc_cnt - start < 10000 && cyc < 60000) begin
            if (!(in_valid && !acc)) begin
                in_valid = 1'($urandom_range(0, 1));
                in_data  = 8'($urandom);
            end
            out_ready = 1'($urandom_range(0, 1));
            clr = ($urandom_range(0, 63) == 0);
            cycle();
            cyc++;
        end
        check("random_budget", {31'b0, cyc < 60000}, 32'd1);
        clr = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        cycle();
        cycle();
        cycle();
        check("final_empty", {30'b0, occupancy}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
